// File: rtl/leaf_shell_pkg.sv
// Shared leaf-shell constants, output-register state type and a constant log2 helper.
package leaf_shell_pkg;

  localparam int PAYLOAD_BITS = 32;
  localparam int PACKET_BITS  = 49;

  typedef enum logic {
    OREG_EMPTY = 1'b0,
    OREG_VALID = 1'b1
  } oreg_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/leaf_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read of the address being written in the same cycle returns the new word.
module leaf_sdp_ram #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write-first forwarding lets a word pushed into a drained RAM land in the
  // read register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/leaf_user_stream_fifo.sv
// Per-port elastic buffer from leaf_interface to the user kernel, with
// registered output word and block-granular freespace credit return.
module leaf_user_stream_fifo #(
  parameter int PAYLOAD_BITS = leaf_shell_pkg::PAYLOAD_BITS,
  parameter int ADDR_BITS    = 7,
  parameter int UPDATE_SIZE  = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [ADDR_BITS:0]      count,
  output logic                    credit_upd,
  output logic                    overflow_err
);

  import leaf_shell_pkg::*;

  localparam int                   DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_CNT = (ADDR_BITS+1)'(DEPTH);
  localparam int                   UPD_BITS = clog2(UPDATE_SIZE);
  localparam logic [ADDR_BITS-1:0] UPD_MASK = ADDR_BITS'((1 << UPD_BITS) - 1);

  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr, pop_cnt;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 rdy_q, ovf_q, credit_q;
  logic                 push, pop, ram_avail, load;
  oreg_state_e          state_q, state_d;

  assign vld_out      = (state_q == OREG_VALID);
  assign ack_out      = rdy_q;
  assign count        = count_q;
  assign credit_upd   = credit_q;
  assign overflow_err = ovf_q;

  assign push = vld_in & rdy_q;
  assign pop  = vld_out & ack_in;

  // count includes the word parked in dout; the RAM holds the rest.
  assign ram_avail = (count_q != {{ADDR_BITS{1'b0}}, vld_out});
  assign load      = (~vld_out | pop) & (ram_avail | push);
  assign count_d   = count_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      OREG_EMPTY: if (load) state_d = OREG_VALID;
      OREG_VALID: if (pop && !load) state_d = OREG_EMPTY;
      default:    state_d = OREG_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= OREG_EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_cnt  <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr   <= wr_ptr + ADDR_BITS'(push);
      rd_ptr   <= rd_ptr + ADDR_BITS'(load);
      count_q  <= count_d;
      // Ready is computed from next occupancy so it never looks at vld_in combinationally.
      rdy_q    <= (count_d != FULL_CNT);
      ovf_q    <= ovf_q | (vld_in & (count_q == FULL_CNT));
      pop_cnt  <= pop_cnt + ADDR_BITS'(pop);
      credit_q <= pop && ((pop_cnt & UPD_MASK) == UPD_MASK);
    end
  end

  leaf_sdp_ram #(
    .DATA_BITS (PAYLOAD_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (load),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_leaf_user_stream_fifo.sv
// Directed bench for leaf_user_stream_fifo: vector table plus multi-cycle sequences.
module tb_leaf_user_stream_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] din = '0;
  logic        vld_in = 1'b0;
  logic        ack_out;
  logic [31:0] dout;
  logic        vld_out;
  logic        ack_in = 1'b0;
  logic [7:0]  count;
  logic        credit_upd;
  logic        overflow_err;

  always #5 clk = ~clk;

  leaf_user_stream_fifo #(
    .PAYLOAD_BITS (32),
    .ADDR_BITS    (7),
    .UPDATE_SIZE  (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .vld_in       (vld_in),
    .ack_out      (ack_out),
    .dout         (dout),
    .vld_out      (vld_out),
    .ack_in       (ack_in),
    .count        (count),
    .credit_upd   (credit_upd),
    .overflow_err (overflow_err)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        a;
    logic        e_vld;
    logic [31:0] e_dout;
    int          e_cnt;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  int          m_push, m_pops, n_credit;
  logic        m_ovf;
  vec_t        vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_push = 0; m_pops = 0; n_credit = 0; m_ovf = 1'b0;
  endtask

  // Drive one cycle, advance the reference queue, check every observable output.
  task automatic step(input logic v, input logic [31:0] d, input logic a);
    logic        acc, pp, exp_cr;
    logic [31:0] pd;
    vld_in = v; din = d; ack_in = a;
    #1;
    chk("ack_vs_full", ack_out, (sb.size() != 128));
    acc = v & ack_out;
    pp  = vld_out & a;
    pd  = dout;
    if (v && sb.size() == 128) m_ovf = 1'b1;
    @(posedge clk); #1;
    if (acc) begin sb.push_back(d); m_push++; end
    if (pp) begin
      m_pops++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none", pd);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (pd !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", pd, e);
        end
      end
    end
    exp_cr = pp && (m_pops % 64 == 0);
    if (credit_upd) n_credit++;
    chk("credit_upd", credit_upd, exp_cr);
    chk("count", count, sb.size());
    chk("vld_out", vld_out, (sb.size() != 0));
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    vld_in = 1'b0; ack_in = 1'b0;
    reset_n = 1'b0;
    model_clear();
    reset_release();
  endtask

  initial begin
    model_clear();

    // Reset with a pending word on the input
    vld_in = 1'b1; din = 32'hA5A5_0001; ack_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_out", ack_out, 1'b0);
    chk("rst_vld_out", vld_out, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 32'h0);
    vld_in = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack_out", ack_out, 1'b1);
    chk("post_rst_count", count, 0);
    chk("post_rst_vld_out", vld_out, 1'b0);
    chk("post_rst_credit", credit_upd, 1'b0);
    chk("post_rst_ovf", overflow_err, 1'b0);

    // Short table: single word, queued pairs, push+pop at one and two words
    vecs[0] = '{1'b1, 32'h0000_00AA, 1'b1, 1'b1, 32'h0000_00AA, 1};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0};
    vecs[2] = '{1'b1, 32'h11,        1'b0, 1'b1, 32'h11,        1};
    vecs[3] = '{1'b1, 32'h22,        1'b0, 1'b1, 32'h11,        2};
    vecs[4] = '{1'b1, 32'h33,        1'b1, 1'b1, 32'h22,        2};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h33,        1};
    vecs[6] = '{1'b1, 32'h44,        1'b1, 1'b1, 32'h44,        1};
    vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h44,        1};
    vecs[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].a);
      chk($sformatf("vec%0d_vld", i), vld_out, vecs[i].e_vld);
      chk($sformatf("vec%0d_cnt", i), count, vecs[i].e_cnt);
      if (vecs[i].e_vld) chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
    end

    // Fill to full plus one overflow word, then drain in order
    apply_reset();
    for (int i = 0; i < 129; i++) step(1'b1, 32'(i), 1'b0);
    chk("fill_count", count, 128);
    chk("fill_ack_out", ack_out, 1'b0);
    chk("fill_overflow", overflow_err, 1'b1);
    for (int i = 0; i < 128; i++) begin
      chk("drain_dout", dout, 32'(i));
      step(1'b0, 32'h0, 1'b1);
    end
    chk("drain_count", count, 0);

    // Credit pulses over a 200-word stream with random kernel stalls
    apply_reset();
    for (int c = 0; c < 3000 && m_pops < 200; c++)
      step(m_push < 200, 32'h1000 + 32'(m_push), 1'($urandom_range(0, 1)));
    chk("credit_stream_done", m_pops, 200);
    step(1'b0, 32'h0, 1'b1);
    chk("credit_pulses", n_credit, 3);

    // Sustained push+pop at occupancy one
    apply_reset();
    step(1'b1, 32'h200, 1'b0);
    for (int i = 1; i <= 50; i++) begin
      step(1'b1, 32'h200 + 32'(i), 1'b1);
      chk("simul_count", count, 1);
      chk("simul_dout", dout, 32'h200 + 32'(i));
    end
    step(1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-run, then a fresh stream
    apply_reset();
    for (int i = 0; i < 37; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
    chk("mid_count", count, 37);
    vld_in = 1'b0; ack_in = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_vld_out", vld_out, 1'b0);
    chk("mid_rst_dout", dout, 32'h0);
    chk("mid_rst_ack_out", ack_out, 1'b0);
    chk("mid_rst_credit", credit_upd, 1'b0);
    model_clear();
    reset_release();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h100 + 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("post_mid_pops", m_pops, 20);
    chk("post_mid_credits", n_credit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
